// File: rtl/periph_bus_pkg.sv
// Shared types and helpers for the peripheral bus mux: FSM state encoding,
// wait-count width and packed-parameter field extraction.
package periph_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam int WAIT_W      = 4;
  localparam int SLICE_VEC_W = 1024;

  // Returns field idx (each width bits wide) of a zero-padded packed vector.
  function automatic logic [63:0] field_slice(input logic [SLICE_VEC_W-1:0] vec,
                                              input int idx, input int width);
    logic [SLICE_VEC_W-1:0] shifted;
    shifted     = vec >> (idx * width);
    field_slice = shifted[63:0] & ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/periph_window_match.sv
// One address window comparator: hit when the bus is owned, the masked address
// matches the base and a strobe of the window's type (I/O or memory) is active.
module periph_window_match
  import periph_bus_pkg::*;
#(
  parameter int              ADDR_WIDTH = 20,
  parameter logic [ADDR_WIDTH-1:0] BASE = {ADDR_WIDTH{1'b0}},
  parameter logic [ADDR_WIDTH-1:0] MASK = {ADDR_WIDTH{1'b0}},
  parameter logic            IS_MEM     = 1'b0
) (
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  address_enable_n,
  input  logic                  io_read_n,
  input  logic                  io_write_n,
  input  logic                  memory_read_n,
  input  logic                  memory_write_n,
  output logic                  hit
);

  logic strobe_s;
  logic match_s;

  assign strobe_s = IS_MEM ? (~memory_read_n | ~memory_write_n)
                           : (~io_read_n | ~io_write_n);
  assign match_s  = ((address ^ BASE) & MASK) == {ADDR_WIDTH{1'b0}};
  assign hit      = ~address_enable_n & match_s & strobe_s;

endmodule

// File: rtl/periph_bus_mux.sv
// Address-window chip-select decoder with per-channel wait states, ready
// extension, timeout, and a registered read-data return path (incl. INTA).
module periph_bus_mux
  import periph_bus_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int ADDR_WIDTH   = 20,
  parameter int DATA_WIDTH   = 8,
  parameter logic [NUM_CHANNELS*ADDR_WIDTH-1:0] CH_BASE = {(NUM_CHANNELS*ADDR_WIDTH){1'b0}},
  parameter logic [NUM_CHANNELS*ADDR_WIDTH-1:0] CH_MASK = {(NUM_CHANNELS*ADDR_WIDTH){1'b0}},
  parameter logic [NUM_CHANNELS-1:0]            CH_IS_MEM = {NUM_CHANNELS{1'b0}},
  parameter logic [NUM_CHANNELS*WAIT_W-1:0]     CH_WAIT = {(NUM_CHANNELS*WAIT_W){1'b0}},
  parameter int INTA_CHANNEL = 1,
  parameter int TIMEOUT      = 64
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [ADDR_WIDTH-1:0]              address,
  input  logic                               address_enable_n,
  input  logic                               io_read_n,
  input  logic                               io_write_n,
  input  logic                               memory_read_n,
  input  logic                               memory_write_n,
  input  logic                               interrupt_acknowledge_n,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] channel_data_in,
  input  logic [NUM_CHANNELS-1:0]            channel_ready,
  output logic [NUM_CHANNELS-1:0]            chip_select_n,
  output logic                               ready,
  output logic [DATA_WIDTH-1:0]              data_bus_out,
  output logic                               data_bus_out_from_chipset,
  output logic                               timeout_pulse
);

  localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int TCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int PAD_A  = SLICE_VEC_W - NUM_CHANNELS * ADDR_WIDTH;
  localparam int PAD_W  = SLICE_VEC_W - NUM_CHANNELS * WAIT_W;
  localparam logic [CH_W-1:0]   INTA_CH   = CH_W'(INTA_CHANNEL);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  logic [NUM_CHANNELS-1:0] hit_s;
  logic [WAIT_W-1:0]       ch_wait_s [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   ch_data_s [NUM_CHANNELS];
  logic [CH_W-1:0]         hit_idx_s;
  logic                    any_hit_s;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    localparam logic [ADDR_WIDTH-1:0] BASE_I =
      ADDR_WIDTH'(field_slice({{PAD_A{1'b0}}, CH_BASE}, i, ADDR_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] MASK_I =
      ADDR_WIDTH'(field_slice({{PAD_A{1'b0}}, CH_MASK}, i, ADDR_WIDTH));

    assign ch_wait_s[i] = WAIT_W'(field_slice({{PAD_W{1'b0}}, CH_WAIT}, i, WAIT_W));
    assign ch_data_s[i] = channel_data_in[i*DATA_WIDTH +: DATA_WIDTH];

    periph_window_match #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BASE       (BASE_I),
      .MASK       (MASK_I),
      .IS_MEM     (CH_IS_MEM[i])
    ) u_match (
      .address          (address),
      .address_enable_n (address_enable_n),
      .io_read_n        (io_read_n),
      .io_write_n       (io_write_n),
      .memory_read_n    (memory_read_n),
      .memory_write_n   (memory_write_n),
      .hit              (hit_s[i])
    );
  end

  // Lowest-index hit wins: scan downward so the last assignment is the lowest.
  always_comb begin
    hit_idx_s = {CH_W{1'b0}};
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      hit_idx_s = hit_s[i] ? CH_W'(i) : hit_idx_s;
    end
  end

  assign any_hit_s     = |hit_s;
  assign chip_select_n = any_hit_s ? ~(NUM_CHANNELS'(1'b1) << hit_idx_s)
                                   : {NUM_CHANNELS{1'b1}};

  // Access qualification; a read+write pair on the hit window is ignored.
  logic              hit_is_mem_s, rd_s, wr_s, inta_s, start_s, start_rd_s;
  logic [CH_W-1:0]   start_ch_s;
  logic [WAIT_W-1:0] start_wait_s;

  assign hit_is_mem_s = CH_IS_MEM[hit_idx_s];
  assign rd_s         = hit_is_mem_s ? ~memory_read_n  : ~io_read_n;
  assign wr_s         = hit_is_mem_s ? ~memory_write_n : ~io_write_n;
  assign inta_s       = ~interrupt_acknowledge_n;
  assign start_s      = inta_s | (any_hit_s & (rd_s ^ wr_s));
  assign start_ch_s   = inta_s ? INTA_CH : hit_idx_s;
  assign start_rd_s   = inta_s | rd_s;
  assign start_wait_s = ch_wait_s[start_ch_s];

  state_t                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic                  rd_q, rd_d, mem_q, mem_d, inta_q, inta_d, to_q, to_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic                  ready_q, ready_d, from_chipset_q, from_chipset_d;
  logic                  timeout_pulse_q, timeout_pulse_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  latched_strobe_n_s;

  assign latched_strobe_n_s = inta_q ? interrupt_acknowledge_n :
                              mem_q  ? (rd_q ? memory_read_n : memory_write_n) :
                                       (rd_q ? io_read_n     : io_write_n);

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d         = state_q;
    ch_d            = ch_q;
    rd_d            = rd_q;
    mem_d           = mem_q;
    inta_d          = inta_q;
    to_d            = to_q;
    cnt_d           = cnt_q;
    tcnt_d          = tcnt_q;
    data_d          = data_q;
    from_chipset_d  = from_chipset_q;
    timeout_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        data_d         = {DATA_WIDTH{1'b0}};
        from_chipset_d = 1'b0;
        to_d           = 1'b0;
        if (start_s) begin
          ch_d   = start_ch_s;
          rd_d   = start_rd_s;
          mem_d  = hit_is_mem_s;
          inta_d = inta_s;
          if (start_wait_s != {WAIT_W{1'b0}}) begin
            state_d = WAIT;
            cnt_d   = start_wait_s - WAIT_W'(1);
            tcnt_d  = {TCNT_W{1'b0}};
          end else begin
            state_d        = ACTIVE;
            data_d         = start_rd_s ? ch_data_s[start_ch_s] : {DATA_WIDTH{1'b0}};
            from_chipset_d = start_rd_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        cnt_d  = (cnt_q == {WAIT_W{1'b0}}) ? cnt_q : cnt_q - WAIT_W'(1);
        if ((cnt_q == {WAIT_W{1'b0}}) && channel_ready[ch_q]) begin
          state_d        = ACTIVE;
          data_d         = rd_q ? ch_data_s[ch_q] : {DATA_WIDTH{1'b0}};
          from_chipset_d = rd_q;
        end else if (tcnt_q == TCNT_LAST) begin
          // Forced completion returns all-ones and holds it for this access.
          state_d         = ACTIVE;
          to_d            = 1'b1;
          timeout_pulse_d = 1'b1;
          data_d          = rd_q ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
          from_chipset_d  = rd_q;
        end else begin
          state_d = WAIT;
        end
      end
      ACTIVE: begin
        if (latched_strobe_n_s) begin
          state_d        = IDLE;
          data_d         = {DATA_WIDTH{1'b0}};
          from_chipset_d = 1'b0;
          to_d           = 1'b0;
        end else begin
          data_d = (rd_q & ~to_q) ? ch_data_s[ch_q] : data_q;
        end
      end
      default: begin
        state_d        = IDLE;
        data_d         = {DATA_WIDTH{1'b0}};
        from_chipset_d = 1'b0;
      end
    endcase
    ready_d = (state_d != WAIT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      ch_q            <= {CH_W{1'b0}};
      rd_q            <= 1'b0;
      mem_q           <= 1'b0;
      inta_q          <= 1'b0;
      to_q            <= 1'b0;
      cnt_q           <= {WAIT_W{1'b0}};
      tcnt_q          <= {TCNT_W{1'b0}};
      ready_q         <= 1'b1;
      data_q          <= {DATA_WIDTH{1'b0}};
      from_chipset_q  <= 1'b0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ch_q            <= ch_d;
      rd_q            <= rd_d;
      mem_q           <= mem_d;
      inta_q          <= inta_d;
      to_q            <= to_d;
      cnt_q           <= cnt_d;
      tcnt_q          <= tcnt_d;
      ready_q         <= ready_d;
      data_q          <= data_d;
      from_chipset_q  <= from_chipset_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign ready                     = ready_q;
  assign data_bus_out              = data_q;
  assign data_bus_out_from_chipset = from_chipset_q;
  assign timeout_pulse             = timeout_pulse_q;

endmodule

// File: tb/tb_periph_bus_mux.sv
// Self-checking bench for periph_bus_mux: directed scenarios plus randomized
// accesses against a window/latency reference model.
module tb_periph_bus_mux;

  localparam int N = 8, AW = 20, DW = 8, TO = 64;

  // Reference map, channel 0 first.
  localparam logic [19:0] M_BASE [8] = '{20'h00000, 20'h00020, 20'h00080, 20'h00060,
                                         20'hC0000, 20'hB8000, 20'h00080, 20'h003F0};
  localparam logic [19:0] M_MASK [8] = '{20'hF0000, 20'h003E0, 20'h003F0, 20'h003F0,
                                         20'hF0000, 20'hFC000, 20'h003C0, 20'h003F8};
  localparam bit M_MEM  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam int M_WAIT [8] = '{0, 0, 1, 2, 15, 3, 0, 5};
  localparam int IO_CH  [5] = '{1, 2, 3, 6, 7};
  localparam int MEM_CH [3] = '{0, 4, 5};

  localparam logic [N*AW-1:0] P_BASE = {20'h003F0, 20'h00080, 20'hB8000, 20'hC0000,
                                        20'h00060, 20'h00080, 20'h00020, 20'h00000};
  localparam logic [N*AW-1:0] P_MASK = {20'h003F8, 20'h003C0, 20'hFC000, 20'hF0000,
                                        20'h003F0, 20'h003F0, 20'h003E0, 20'hF0000};
  localparam logic [N-1:0]    P_MEM  = 8'b0011_0001;
  localparam logic [N*4-1:0]  P_WAIT = {4'd5, 4'd0, 4'd3, 4'd15, 4'd2, 4'd1, 4'd0, 4'd0};

  logic            clock, reset_n;
  logic [AW-1:0]   address;
  logic            aen_n, iord_n, iowr_n, mrd_n, mwr_n, inta_n;
  logic [N*DW-1:0] cdin;
  logic [N-1:0]    cready, cs_n;
  logic            ready, fc, tpulse;
  logic [DW-1:0]   dout;

  int checks   = 0;
  int failures = 0;

  periph_bus_mux #(
    .NUM_CHANNELS (N), .ADDR_WIDTH (AW), .DATA_WIDTH (DW),
    .CH_BASE (P_BASE), .CH_MASK (P_MASK), .CH_IS_MEM (P_MEM), .CH_WAIT (P_WAIT),
    .INTA_CHANNEL (1), .TIMEOUT (TO)
  ) dut (
    .clock (clock), .reset_n (reset_n), .address (address),
    .address_enable_n (aen_n), .io_read_n (iord_n), .io_write_n (iowr_n),
    .memory_read_n (mrd_n), .memory_write_n (mwr_n),
    .interrupt_acknowledge_n (inta_n), .channel_data_in (cdin),
    .channel_ready (cready), .chip_select_n (cs_n), .ready (ready),
    .data_bus_out (dout), .data_bus_out_from_chipset (fc),
    .timeout_pulse (tpulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_idle();
    aen_n = 1'b1; iord_n = 1'b1; iowr_n = 1'b1; mrd_n = 1'b1; mwr_n = 1'b1;
    inta_n = 1'b1; address = 20'h00000; cready = 8'hFF;
  endtask

  function automatic int model_channel(logic [19:0] a);
    for (int i = 0; i < N; i++) begin
      bit strobe;
      strobe = M_MEM[i] ? (!mrd_n || !mwr_n) : (!iord_n || !iowr_n);
      if (!aen_n && strobe && ((a & M_MASK[i]) == (M_BASE[i] & M_MASK[i]))) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_cs(int ch);
    logic [7:0] one;
    one = 8'h01;
    return (ch < 0) ? 8'hFF : ~(one << ch);
  endfunction

  // One complete access: decode, ready-low window, data/flag, hold, release.
  task automatic run_access(input string tag, input int kind, input bit is_read,
                            input logic [19:0] a, input int stall, input int hold,
                            input int fixed_byte);
    int ch, w, off, eff;
    bit rd, tmo;
    logic [7:0] exp_d;
    rd = (kind == 2) || is_read;
    address = a; aen_n = 1'b0;
    iord_n = !(kind == 0 && rd);  iowr_n = !(kind == 0 && !rd);
    mrd_n  = !(kind == 1 && rd);  mwr_n  = !(kind == 1 && !rd);
    inta_n = !(kind == 2);
    cdin = {$urandom, $urandom};
    ch = model_channel(a);
    #1;
    checks++;
    if (cs_n !== model_cs(ch)) begin
      failures++; $display("FAIL %s cs_n got=%h exp=%h", tag, cs_n, model_cs(ch));
    end
    if (kind == 2) ch = 1;
    if (ch < 0) ch = 0;
    if (fixed_byte >= 0) cdin[ch*8 +: 8] = 8'(fixed_byte);
    w   = M_WAIT[ch];
    eff = (w > stall) ? w : stall;
    off = (w == 0) ? 0 : ((eff < TO) ? eff : TO);
    tmo = (w != 0) && (eff > TO);
    cready = 8'hFF;
    if (stall > 0) cready[ch] = 1'b0;
    tick();
    for (int j = 1; j <= off; j++) begin
      checks++;
      if (ready !== 1'b0 || fc !== 1'b0 || tpulse !== 1'b0) begin
        failures++;
        $display("FAIL %s wait%0d ready=%b fc=%b tp=%b exp 0/0/0", tag, j, ready, fc, tpulse);
      end
      cready[ch] = (j >= stall);
      tick();
    end
    exp_d = !rd ? 8'h00 : (tmo ? 8'hFF : cdin[ch*8 +: 8]);
    checks++;
    if (ready !== 1'b1 || fc !== rd || tpulse !== tmo) begin
      failures++;
      $display("FAIL %s done ready=%b fc=%b tp=%b exp 1/%b/%b", tag, ready, fc, tpulse, rd, tmo);
    end
    checks++;
    if (dout !== exp_d) begin
      failures++; $display("FAIL %s data got=%h exp=%h", tag, dout, exp_d);
    end
    for (int h = 0; h < hold; h++) begin
      cdin = {$urandom, $urandom};
      tick();
      checks++;
      if (tpulse !== 1'b0 || fc !== rd || ready !== 1'b1) begin
        failures++; $display("FAIL %s hold tp=%b fc=%b ready=%b", tag, tpulse, fc, ready);
      end
      if (!tmo) begin
        exp_d = rd ? cdin[ch*8 +: 8] : 8'h00;
        checks++;
        if (dout !== exp_d) begin
          failures++; $display("FAIL %s reload got=%h exp=%h", tag, dout, exp_d);
        end
      end
    end
    iord_n = 1'b1; iowr_n = 1'b1; mrd_n = 1'b1; mwr_n = 1'b1; inta_n = 1'b1;
    tick();
    checks++;
    if (fc !== 1'b0 || dout !== 8'h00 || ready !== 1'b1 || cs_n !== 8'hFF) begin
      failures++;
      $display("FAIL %s release fc=%b data=%h ready=%b cs=%h exp 0/00/1/FF", tag, fc, dout, ready, cs_n);
    end
    cready = 8'hFF;
  endtask

  task automatic test_reset();
    bus_idle(); cdin = 64'h0; reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (ready !== 1'b1 || dout !== 8'h00 || fc !== 1'b0 || tpulse !== 1'b0 || cs_n !== 8'hFF) begin
      failures++;
      $display("FAIL reset ready=%b data=%h fc=%b tp=%b cs=%h exp 1/00/0/0/FF", ready, dout, fc, tpulse, cs_n);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_directed_reads();
    run_access("io_read_ch1", 0, 1'b1, 20'h00021, 0, 1, 8'hA5);
    run_access("mem_wait_ch5", 1, 1'b1, 20'hB8123, 0, 1, -1);
    run_access("ready_ext_ch3", 0, 1'b1, 20'h00065, 10, 1, -1);
    run_access("timeout_ch3", 0, 1'b1, 20'h00066, 70, 1, -1);
    run_access("long_wait_ch4", 1, 1'b1, 20'hC1234, 0, 0, -1);
  endtask

  task automatic test_writes();
    run_access("io_write_ch7", 0, 1'b0, 20'h003F2, 0, 1, -1);
    run_access("mem_write_ch0", 1, 1'b0, 20'h04321, 0, 1, -1);
  endtask

  task automatic test_overlap_and_enable();
    address = 20'h00085; aen_n = 1'b0; iord_n = 1'b0;
    #1;
    checks++;
    if (cs_n !== 8'hFB) begin failures++; $display("FAIL overlap cs got=%h exp=FB", cs_n); end
    address = 20'h000A0;
    #1;
    checks++;
    if (cs_n !== 8'hBF) begin failures++; $display("FAIL ch6_only cs got=%h exp=BF", cs_n); end
    address = 20'h00021; aen_n = 1'b1;
    #1;
    checks++;
    if (cs_n !== 8'hFF) begin failures++; $display("FAIL aen_high cs got=%h exp=FF", cs_n); end
    repeat (2) tick();
    checks++;
    if (ready !== 1'b1 || fc !== 1'b0 || dout !== 8'h00) begin
      failures++; $display("FAIL aen_high access ready=%b fc=%b data=%h", ready, fc, dout);
    end
    bus_idle(); tick();
    run_access("overlap_read", 0, 1'b1, 20'h00085, 0, 0, -1);
  endtask

  task automatic test_inta_and_conflict();
    run_access("inta", 2, 1'b1, 20'h00000, 0, 1, 8'h08);
    address = 20'h00021; aen_n = 1'b0; iord_n = 1'b0; iowr_n = 1'b0;
    #1;
    checks++;
    if (cs_n !== 8'hFD) begin failures++; $display("FAIL rw_both cs got=%h exp=FD", cs_n); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ready !== 1'b1 || fc !== 1'b0 || dout !== 8'h00) begin
        failures++; $display("FAIL rw_both cyc%0d ready=%b fc=%b data=%h exp 1/0/00", i, ready, fc, dout);
      end
    end
    bus_idle(); tick();
  endtask

  task automatic test_reset_mid_access();
    address = 20'hB8123; aen_n = 1'b0; mrd_n = 1'b0;
    tick(); tick();
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL mid_reset pre ready got=%b exp=0", ready); end
    reset_n = 1'b0;
    tick();
    checks++;
    if (ready !== 1'b1 || fc !== 1'b0 || dout !== 8'h00 || tpulse !== 1'b0) begin
      failures++; $display("FAIL mid_reset ready=%b fc=%b data=%h tp=%b exp 1/0/00/0", ready, fc, dout, tpulse);
    end
    reset_n = 1'b1; bus_idle();
    tick();
    run_access("after_reset", 1, 1'b1, 20'hB8040, 0, 1, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int kind, ch, stall, r;
      bit rd;
      logic [19:0] a;
      kind = ($urandom_range(0, 9) < 5) ? 0 : (($urandom_range(0, 9) < 8) ? 1 : 2);
      ch = (kind == 1) ? MEM_CH[$urandom_range(0, 2)] : IO_CH[$urandom_range(0, 4)];
      a = (M_BASE[ch] & M_MASK[ch]) | (20'($urandom) & ~M_MASK[ch]);
      rd = 1'($urandom);
      r = $urandom_range(0, 9);
      stall = (r < 6) ? $urandom_range(0, 8) : ((r < 9) ? $urandom_range(9, 20) : 70);
      run_access($sformatf("rand%0d", it), kind, rd, a, stall, $urandom_range(0, 2), -1);
    end
  endtask

  initial begin
    reset_n = 1'b0; bus_idle(); cdin = 64'h0;
    test_reset();
    test_directed_reads();
    test_writes();
    test_overlap_and_enable();
    test_inta_and_conflict();
    test_reset_mid_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
